// File: rtl/fpu_share_arbiter.sv
// Round-robin arbiter sharing one iterative FPU function unit among four requesters.
// Optional WAIT-state timeout enabled by defining FPU_SHARE_ARBITER_TIMEOUT_EN.
module fpu_share_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [127:0] x_in,
    output logic [3:0]   gnt,
    output logic         fu_start,
    output logic [31:0]  fu_x,
    input  logic         fu_done,
    input  logic [31:0]  fu_y,
    output logic [31:0]  y_out,
    output logic [3:0]   y_valid,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state;
    logic [1:0] owner;
    logic [1:0] last_winner;
    logic [1:0] winner;
    logic       any_req;

    // Scan farthest-to-nearest so the requester closest after last_winner is assigned last and wins.
    always_comb begin
        winner  = last_winner + 2'd1;
        any_req = |req;
        for (int k = 4; k >= 1; k--) begin
            if (req[last_winner + 2'(k)]) begin
                winner = last_winner + 2'(k);
            end
        end
    end

`ifdef FPU_SHARE_ARBITER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 2'd0;
            last_winner <= 2'd3;
            gnt         <= 4'b0000;
            fu_start    <= 1'b0;
            fu_x        <= 32'h0;
            y_out       <= 32'h0;
            y_valid     <= 4'b0000;
            busy        <= 1'b0;
`ifdef FPU_SHARE_ARBITER_TIMEOUT_EN
            err         <= 1'b0;
            wait_cnt    <= '0;
            timed_out   <= 1'b0;
`endif
        end else begin
            gnt      <= 4'b0000;
            fu_start <= 1'b0;
            y_valid  <= 4'b0000;
`ifdef FPU_SHARE_ARBITER_TIMEOUT_EN
            err      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (any_req) begin
                        fu_x     <= x_in[{winner, 5'b00000} +: 32];
                        owner    <= winner;
                        gnt      <= 4'b0001 << winner;
                        fu_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= START;
`ifdef FPU_SHARE_ARBITER_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (fu_done) begin
                        y_out <= fu_y;
                        state <= RESP;
`ifdef FPU_SHARE_ARBITER_TIMEOUT_EN
                    end else if (wait_cnt == CNT_LAST) begin
                        // Unit never answered: hand back a quiet NaN and flag it.
                        y_out     <= 32'h7FC00000;
                        timed_out <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    y_valid     <= 4'b0001 << owner;
                    last_winner <= owner;
                    busy        <= 1'b0;
                    state       <= IDLE;
`ifdef FPU_SHARE_ARBITER_TIMEOUT_EN
                    err         <= timed_out;
                    timed_out   <= 1'b0;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Directed self-checking bench for fpu_share_arbiter; the function unit is emulated by hand-driven fu_done/fu_y.
module tb_fpu_share_arbiter;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] x_in;
    logic [3:0]   gnt;
    logic         fu_start;
    logic [31:0]  fu_x;
    logic         fu_done;
    logic [31:0]  fu_y;
    logic [31:0]  y_out;
    logic [3:0]   y_valid;
    logic         busy;
    logic         err;

    int vectors     = 0;
    int miscompares = 0;

    fpu_share_arbiter #(.TIMEOUT_CYCLES(10)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .x_in     (x_in),
        .gnt      (gnt),
        .fu_start (fu_start),
        .fu_x     (fu_x),
        .fu_done  (fu_done),
        .fu_y     (fu_y),
        .y_out    (y_out),
        .y_valid  (y_valid),
        .busy     (busy),
        .err      (err)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Caller sets req/x_in in an IDLE cycle; the first tick is the sampling edge.
    task automatic run_txn(input string tag, input int owner, input logic [31:0] x_exp,
                           input logic [31:0] y, input int d,
                           input logic [3:0] req_after, input logic [127:0] x_after);
        tick;
        check({tag, ".gnt"},      32'(gnt),      32'(4'b0001 << owner));
        check({tag, ".fu_start"}, 32'(fu_start), 32'd1);
        check({tag, ".fu_x"},     fu_x,          x_exp);
        check({tag, ".busy"},     32'(busy),     32'd1);
        check({tag, ".yv_low"},   32'(y_valid),  32'd0);
        req  = req_after;
        x_in = x_after;
        tick;
        check({tag, ".gnt_pulse"},   32'(gnt),      32'd0);
        check({tag, ".start_pulse"}, 32'(fu_start), 32'd0);
        repeat (d - 1) tick;
        check({tag, ".fu_x_hold"}, fu_x, x_exp);
        fu_done = 1'b1;
        fu_y    = y;
        tick;
        fu_done = 1'b0;
        fu_y    = 32'h0;
        check({tag, ".yv_resp"}, 32'(y_valid), 32'd0);
        tick;
        check({tag, ".y_valid"}, 32'(y_valid), 32'(4'b0001 << owner));
        check({tag, ".y_out"},   y_out,        y);
        check({tag, ".busy_end"}, 32'(busy),   32'd0);
        check({tag, ".err"},     32'(err),     32'd0);
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        tick;
        reset = 1'b0;
    endtask

    localparam logic [127:0] OPS = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};

    initial begin
        reset   = 1'b1;
        req     = 4'b0000;
        x_in    = '0;
        fu_done = 1'b0;
        fu_y    = 32'h0;
        tick;
        check("rst.gnt",      32'(gnt),      32'd0);
        check("rst.y_valid",  32'(y_valid),  32'd0);
        check("rst.fu_start", 32'(fu_start), 32'd0);
        check("rst.busy",     32'(busy),     32'd0);
        check("rst.err",      32'(err),      32'd0);
        check("rst.fu_x",     fu_x,          32'h0);
        check("rst.y_out",    y_out,         32'h0);
        reset = 1'b0;
        tick;

        // Single requester 2, done 5 cycles after start; req drops and x_in changes after gnt.
        req  = 4'b0100;
        x_in = {32'h0, 32'h40000000, 64'h0};
        run_txn("single2", 2, 32'h40000000, 32'h3FB504F3, 5, 4'b0000, {4{32'hA5A5A5A5}});

        // All four requesting from reset: order 0,1,2,3,0.
        pulse_reset;
        req  = 4'b1111;
        x_in = OPS;
        run_txn("rr0", 0, 32'h3F800000, ~32'h3F800000, 2, 4'b1111, OPS);
        run_txn("rr1", 1, 32'h40000000, ~32'h40000000, 3, 4'b1111, OPS);
        run_txn("rr2", 2, 32'h40400000, ~32'h40400000, 1, 4'b1111, OPS);
        run_txn("rr3", 3, 32'h40800000, ~32'h40800000, 4, 4'b1111, OPS);
        run_txn("rr0b", 0, 32'h3F800000, ~32'h3F800000, 2, 4'b1111, OPS);
        req = 4'b0000;

        // Stray fu_done while IDLE and in START must be ignored.
        fu_done = 1'b1;
        fu_y    = 32'hDEADBEEF;
        tick;
        fu_done = 1'b0;
        check("idle_done.y_valid", 32'(y_valid), 32'd0);
        check("idle_done.busy",    32'(busy),    32'd0);
        check("idle_done.y_out",   y_out,        ~32'h3F800000);
        req = 4'b0100;
        tick;
        check("start_done.gnt", 32'(gnt), 32'(4'b0100));
        req     = 4'b0000;
        fu_done = 1'b1;
        fu_y    = 32'hBADBAD00;
        tick;
        fu_done = 1'b0;
        check("start_done.y_out", y_out,      ~32'h3F800000);
        check("start_done.busy",  32'(busy),  32'd1);
        tick;
        check("start_done.y_valid", 32'(y_valid), 32'd0);
        check("start_done.busy2",   32'(busy),    32'd1);
        fu_done = 1'b1;
        fu_y    = 32'h12345678;
        tick;
        fu_done = 1'b0;
        tick;
        check("wait_done.y_valid", 32'(y_valid), 32'(4'b0100));
        check("wait_done.y_out",   y_out,        32'h12345678);

        // Reset during WAIT for owner 1.
        pulse_reset;
        req = 4'b0010;
        tick;
        check("midrst.gnt", 32'(gnt), 32'(4'b0010));
        req = 4'b0000;
        tick;
        tick;
        #3;
        reset = 1'b1;
        #1;
        check("midrst.gnt0",     32'(gnt),      32'd0);
        check("midrst.y_valid0", 32'(y_valid),  32'd0);
        check("midrst.start0",   32'(fu_start), 32'd0);
        check("midrst.busy0",    32'(busy),     32'd0);
        check("midrst.err0",     32'(err),      32'd0);
        check("midrst.fu_x0",    fu_x,          32'h0);
        check("midrst.y_out0",   y_out,         32'h0);
        @(posedge clock);
        #1;
        reset   = 1'b0;
        fu_done = 1'b1;
        fu_y    = 32'h55555555;
        tick;
        fu_done = 1'b0;
        tick;
        check("midrst.late_done_yv", 32'(y_valid), 32'd0);
        check("midrst.late_busy",    32'(busy),    32'd0);
        check("midrst.late_y_out",   y_out,        32'h0);
        req = 4'b0011;
        run_txn("after_rst", 0, 32'h3F800000, 32'h0BADF00D, 3, 4'b0000, OPS);

        // Unit never answers: requester 3 wins (last winner 0, only 3 requesting).
        req = 4'b1000;
        tick;
        check("hang.gnt", 32'(gnt), 32'(4'b1000));
        req = 4'b0000;
        repeat (12) tick;
`ifdef FPU_SHARE_ARBITER_TIMEOUT_EN
        check("timeout.y_valid", 32'(y_valid), 32'(4'b1000));
        check("timeout.err",     32'(err),     32'd1);
        check("timeout.y_out",   y_out,        32'h7FC00000);
        tick;
        check("timeout.err_pulse", 32'(err),     32'd0);
        check("timeout.busy",      32'(busy),    32'd0);
        check("timeout.yv_pulse",  32'(y_valid), 32'd0);
`else
        check("hang.busy",    32'(busy),    32'd1);
        check("hang.err",     32'(err),     32'd0);
        check("hang.y_valid", 32'(y_valid), 32'd0);
        repeat (20) tick;
        check("hang.busy_late", 32'(busy), 32'd1);
        check("hang.err_late",  32'(err),  32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fpu_share_arbiter.md
FPU_SHARE_ARBITER -- requirements
Module: fpu_share_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the WAIT-state cycle limit when the timeout feature is compiled in.
REQ-002 SHALL have port clock  input  1  the only clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req  input  4  per-requester request, level, held until gnt.
REQ-005 SHALL have port x_in  input  128  packed operands; requester i uses bits [32i+31:32i], IEEE-754 single.
REQ-006 SHALL have port gnt  output  4  one-hot, one-cycle pulse, request accepted.
REQ-007 SHALL have port fu_start  output  1  one-cycle start pulse to the shared function unit.
REQ-008 SHALL have port fu_x  output  32  operand to the function unit, registered.
REQ-009 SHALL have port fu_done  input  1  function unit result-ready pulse.
REQ-010 SHALL have port fu_y  input  32  function unit result, valid when fu_done=1.
REQ-011 SHALL have port y_out  output  32  registered result returned to the owner.
REQ-012 SHALL have port y_valid  output  4  one-hot, one-cycle pulse, y_out belongs to requester i.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port err  output  1  one-cycle timeout flag, coincident with y_valid.

Function
REQ-015 SHALL implement FSM IDLE -> START -> WAIT -> RESP -> IDLE; one transaction in flight at most.
REQ-016 IDLE: SHALL sample req; if any bit set, SHALL select the winner by round-robin, searching from (last_winner+1) mod 4 upward with wrap.
REQ-017 On that edge SHALL latch x_in slice of winner into fu_x, record the owner, and go to START.
REQ-018 START (one cycle): SHALL drive gnt[owner]=1 and fu_start=1; next state WAIT.
REQ-019 WAIT: SHALL hold fu_x stable; on fu_done=1 SHALL capture fu_y into y_out and go to RESP.
REQ-020 RESP (one cycle): SHALL drive y_valid[owner]=1; last_winner updates to owner; next state IDLE.
REQ-021 Latency: req sampled at edge N -> gnt at cycle N+1 -> y_valid exactly 2 cycles after the fu_done cycle; a unit with done D cycles after start gives req-to-y_valid of D+3 cycles.
REQ-022 fu_done in IDLE, START or RESP SHALL be ignored.
REQ-023 req bits dropping before their gnt SHALL be ignored; req changes after winner latched do not alter the transaction.
REQ-024 A requester still requesting in the RESP cycle SHALL be eligible again in the following IDLE cycle, subject to round-robin.
REQ-025 gnt, y_valid, fu_start, err SHALL never be high for more than one consecutive cycle.

Reset
REQ-026 reset=1 SHALL immediately force state IDLE; gnt, y_valid, fu_start, busy, err = 0; fu_x, y_out = 32'h0; last_winner = 3, so requester 0 has top priority first.
REQ-027 Reset mid-transaction SHALL abandon it with no y_valid; a later fu_done SHALL be ignored.

Configuration
REQ-028 Macro FPU_SHARE_ARBITER_TIMEOUT_EN defined: SHALL count WAIT cycles; on reaching TIMEOUT_CYCLES without fu_done, SHALL set y_out=32'h7FC00000 (quiet NaN), go to RESP, and pulse err with y_valid.
REQ-029 Macro undefined: WAIT SHALL persist until fu_done; err SHALL be tied 0; no counter logic.

Verification
REQ-030 Single req[2], x=32'h40000000, unit done 5 cycles after start with y=32'h3FB504F3 -> gnt=4'b0100 one cycle, fu_x=32'h40000000, y_valid=4'b0100 with y_out=32'h3FB504F3, 8 cycles after req.
REQ-031 req=4'b1111 held after reset -> grants in order 0,1,2,3,0; each requester's y_out matches its own operand's result.
REQ-032 fu_done pulsed while IDLE and again in the START cycle -> no capture, no y_valid; only the WAIT-state done is used.
REQ-033 reset asserted during WAIT for owner 1 -> all outputs 0 immediately; subsequent fu_done -> no y_valid; next grant goes to requester 0 if requesting.
REQ-034 With FPU_SHARE_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=10, unit never done -> y_out=32'h7FC00000, y_valid and err high same cycle, then IDLE; without the macro -> busy stays 1, err stays 0.
